// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and widths for the fetch-side PC sequencer.
package pc_seq_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_BYTES = 4;
  localparam int CNT_W       = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } pc_seq_state_t;

  // Clears the byte-offset bits so an address lands on an instruction boundary.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch request handshake between the sequencer and instruction memory.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;

  modport master (output fetch_valid, output fetch_addr, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_addr, output fetch_ready);

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority selector; PC_SEQ_MISALIGN_TRAP_EN enables trapping.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 64'h0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 64'h100
) (
  input  logic              rst_i,
  input  pc_seq_state_t     state_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              fetch_valid_i,
  input  logic              fetch_ready_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              pend_valid_i,
  input  logic [ADDR_W-1:0] pend_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              live_apply_o,
  output logic              pend_apply_o,
  output logic              trap_o,
  output logic              accept_o
);

  logic [ADDR_W-1:0] redir_tgt;

  always_comb begin
    live_apply_o = branch_taken_i && !stall_i && (state_i != BOOT);
    pend_apply_o = pend_valid_i && !stall_i && !live_apply_o;
    accept_o     = fetch_valid_i && fetch_ready_i;
    redir_tgt    = live_apply_o ? branch_target_i : pend_target_i;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    trap_o = (live_apply_o || pend_apply_o) && (redir_tgt[1:0] != 2'b00);
`else
    trap_o    = 1'b0;
    redir_tgt = align_addr(redir_tgt);
`endif
    if (rst_i) begin
      next_pc_o = RESET_VECTOR;
    end else if (trap_o) begin
      next_pc_o = TRAP_VECTOR;
    end else if (live_apply_o || pend_apply_o) begin
      next_pc_o = redir_tgt;
    end else if (accept_o) begin
      next_pc_o = pc_i + ADDR_W'(INSTR_BYTES);
    end else begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer top: FSM, pending redirect and fetch counter.
// PC_SEQ_MISALIGN_TRAP_EN routes misaligned redirect targets to TRAP_VECTOR.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 64'h0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = 64'h100
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_W-1:0]     branch_target_i,
  pc_sequencer_if.master        fetch_if,
  output logic [ADDR_W-1:0]     pc_o,
  output logic [ADDR_W-1:0]     next_pc_o,
  output logic [CNT_W-1:0]      fetch_count_o,
  output logic                  misaligned_o
);

  pc_seq_state_t     state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_t_q;
  logic              mis_q;
  logic              live_apply, pend_apply, trap, accept;

  pc_next_sel #(
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_sel (
    .rst_i           (rst_in),
    .state_i         (state_q),
    .pc_i            (pc_q),
    .fetch_valid_i   (valid_q),
    .fetch_ready_i   (fetch_if.fetch_ready),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pend_valid_i    (pend_v_q),
    .pend_target_i   (pend_t_q),
    .next_pc_o       (pc_d),
    .live_apply_o    (live_apply),
    .pend_apply_o    (pend_apply),
    .trap_o          (trap),
    .accept_o        (accept)
  );

  // fetch_valid is registered alongside the state so it only ever asserts in RUN.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      if (live_apply || pend_apply) begin
        pend_v_q <= 1'b0;
      end else if (branch_taken_i) begin
        pend_v_q <= 1'b1;
        pend_t_q <= branch_target_i;
      end
      if (trap) begin
        mis_q   <= 1'b1;
        state_q <= TRAP;
        valid_q <= 1'b0;
      end else if (stall_i) begin
        state_q <= HOLD;
        valid_q <= 1'b0;
      end else begin
        state_q <= RUN;
        valid_q <= 1'b1;
      end
    end
  end

  assign fetch_if.fetch_valid = valid_q;
  assign fetch_if.fetch_addr  = pc_q;
  assign pc_o                 = pc_q;
  assign next_pc_o            = pc_d;
  assign fetch_count_o        = cnt_q;
  assign misaligned_o         = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized bench for pc_sequencer against a reference model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [63:0] RV = 64'h0;
  localparam logic [63:0] TV = 64'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [63:0] tgt = '0;
  logic [63:0] pc, npc;
  logic [31:0] cnt;
  logic        mis;

  pc_sequencer_if fif ();

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .stall_i         (stall),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .fetch_if        (fif.master),
    .pc_o            (pc),
    .next_pc_o       (npc),
    .fetch_count_o   (cnt),
    .misaligned_o    (mis)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: architectural view of the sequencer.
  logic [63:0] m_pc = RV;
  logic [31:0] m_cnt = 0;
  bit          m_req = 0;
  bit          m_first = 1;
  bit          m_pend_v = 0;
  logic [63:0] m_pend_t = 0;
  bit          m_mis = 0;

  function automatic bit model_redirect(output logic [63:0] t);
    bit live, pend;
    live = br && !stall && !m_first;
    pend = m_pend_v && !stall && !live;
    t = live ? tgt : m_pend_t;
    return live || pend;
  endfunction

  function automatic bit is_bad(input logic [63:0] t);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return (t & 64'h0) != 64'h0;
`endif
  endfunction

  function automatic logic [63:0] exp_next();
    logic [63:0] t;
    if (rst) return RV;
    if (model_redirect(t)) begin
      if (is_bad(t)) return TV;
      return t & ~64'h3;
    end
    if (m_req && fif.fetch_ready) return m_pc + 64'd4;
    return m_pc;
  endfunction

  task automatic model_edge();
    logic [63:0] t, np;
    bit redir;
    if (rst) begin
      m_pc = RV; m_cnt = 0; m_req = 0; m_first = 1;
      m_pend_v = 0; m_pend_t = 0; m_mis = 0;
      return;
    end
    np = exp_next();
    redir = model_redirect(t);
    if (m_req && fif.fetch_ready) m_cnt = m_cnt + 1;
    if (redir) m_pend_v = 0;
    else if (br) begin m_pend_v = 1; m_pend_t = tgt; end
    if (redir && is_bad(t)) m_mis = 1;
    m_req   = !stall && !(redir && is_bad(t));
    m_first = 0;
    m_pc    = np;
  endtask

  task automatic step(input bit s, input bit b, input logic [63:0] t, input bit r, input bit x);
    stall = s; br = b; tgt = t; fif.fetch_ready = r; rst = x;
    #1;
    chk("next_pc", npc, exp_next());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("fetch_addr", fif.fetch_addr, m_pc);
    chk("fetch_valid", 64'(fif.fetch_valid), 64'(m_req));
    chk("fetch_count", 64'(cnt), 64'(m_cnt));
    chk("misaligned", 64'(mis), 64'(m_mis));
  endtask

  initial begin
    logic [63:0] rt;
    fif.fetch_ready = 1'b0;

    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("reset_pc", pc, RV);
    chk("reset_valid", 64'(fif.fetch_valid), 64'd0);
    chk("reset_count", 64'(cnt), 64'd0);
    chk("reset_mis", 64'(mis), 64'd0);

    step(0, 0, 0, 1, 0);
    chk("boot_pc", pc, 64'd0);
    chk("first_valid", 64'(fif.fetch_valid), 64'd1);
    step(0, 0, 0, 1, 0);
    chk("seq_pc4", pc, 64'd4);
    step(0, 0, 0, 1, 0);
    chk("seq_pc8", pc, 64'd8);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_pc", pc, 64'd8);
      chk("hold_valid", 64'(fif.fetch_valid), 64'd1);
    end
    step(0, 0, 0, 1, 0);
    chk("ready_back_pc", pc, 64'd12);
    chk("count3", 64'(cnt), 64'd3);

    step(1, 0, 0, 1, 0);
    step(1, 1, 64'h40, 1, 0);
    step(1, 1, 64'h80, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("pend_newest", pc, 64'h80);
    step(0, 0, 0, 1, 0);
    chk("pend_after", pc, 64'h84);

    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    chk("wrap_setup", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("wrap_pc", pc, 64'd0);
    chk("wrap_noflag", 64'(mis), 64'd0);

    step(0, 1, 64'h42, 1, 0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    chk("mis_pc", pc, 64'h100);
    chk("mis_flag", 64'(mis), 64'd1);
    chk("trap_valid", 64'(fif.fetch_valid), 64'd0);
`else
    chk("mis_pc", pc, 64'h40);
    chk("mis_flag", 64'(mis), 64'd0);
`endif
    step(0, 0, 0, 1, 0);

    step(1, 1, 64'h200, 1, 0);
    step(1, 0, 0, 1, 1);
    chk("rst_mid_pc", pc, RV);
    chk("rst_mid_count", 64'(cnt), 64'd0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rst_pend_dropped", pc, RV + 64'd4);

    for (int i = 0; i < 400; i++) begin
      rt = {$urandom(), $urandom()};
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      step($urandom_range(3) == 0, $urandom_range(9) == 0, rt,
           $urandom_range(9) < 7, $urandom_range(49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller for the 64-bit program counter register. It decides every cycle whether the PC holds, advances by one instruction, or redirects to a branch target. It drives the fetch request to instruction memory over a valid/ready handshake, and it presents `next_pc_o` to the ProgramCounter register input. It sits between branch resolution and stall logic on one side and the PC register and instruction memory on the other.

## Interface
Parameters:
- `RESET_VECTOR`, default 64'h0: PC value after reset.
- `TRAP_VECTOR`, default 64'h100: redirect address on a misaligned target; used only with the macro below.

Ports:
- `clk_in` in 1: the single clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `stall_i` in 1: downstream stall; hold the PC and drop the fetch request.
- `branch_taken_i` in 1: single-cycle redirect strobe.
- `branch_target_i` in 64: redirect address, sampled when `branch_taken_i`=1.
- `fetch_ready_i` in 1: instruction memory accepts the request.
- `fetch_valid_o` out 1: fetch request valid.
- `pc_o` out 64: registered current fetch address.
- `next_pc_o` out 64: combinational value `pc_o` takes at the next edge.
- `fetch_count_o` out 32: number of accepted fetches.
- `misaligned_o` out 1: sticky misaligned-target flag.

## Operation
States:
- BOOT: entered on reset.
- RUN.
- HOLD.
- TRAP: exists only with the macro.

State behaviour:
- BOOT lasts exactly 1 cycle. `fetch_valid_o`=0. Exits to HOLD if `stall_i`=1, otherwise to RUN.
- RUN: `fetch_valid_o`=1. The PC advances by 4 only on acceptance (`fetch_valid_o && fetch_ready_i`).
- While unaccepted, `pc_o` stays stable unless a redirect occurs.
- RUN with `stall_i`=1 goes to HOLD. HOLD: `fetch_valid_o`=0, PC held. HOLD with `stall_i`=0 goes to RUN.

Redirects:
- A redirect in RUN sets PC to the target at the next edge. Any unaccepted request is abandoned (flush), and `fetch_count_o` is not incremented for it.
- A redirect while `stall_i`=1 or in BOOT is latched into a pending register (valid bit plus 64-bit target). It is applied on the first edge where `stall_i`=0, together with the HOLD→RUN transition.
- A second redirect while one is pending overwrites it; the newest target wins.
- A live `branch_taken_i` in the same cycle the pending redirect would apply takes precedence, and pending is cleared.

Priority of `next_pc_o`, highest first:
1. `rst_in`, giving `RESET_VECTOR`.
2. Trap, giving `TRAP_VECTOR`.
3. Live branch, giving `branch_target_i`.
4. Applied pending target.
5. Accepted fetch, giving PC+4.
6. Otherwise hold.

Arithmetic and counter:
- PC+4 is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC advances to 0 with no flag.
- `fetch_count_o` wraps modulo 2^32.

## Timing
- Reset values: `pc_o`=`RESET_VECTOR`, `fetch_valid_o`=0, `fetch_count_o`=0, `misaligned_o`=0, pending cleared, state BOOT.
- `rst_in` asserted mid-operation overrides everything at that edge.
- First possible accepted fetch: cycle 2 after `rst_in` deasserts.
- Redirect latency: 1 edge from the `branch_taken_i` cycle to `pc_o`=target, when not stalled.
- `fetch_valid_o` is a registered function of state, not combinational from `fetch_ready_i`.
- `next_pc_o` is purely combinational from the current state and inputs.

## Configuration
Macro `PC_SEQ_MISALIGN_TRAP_EN`.

When defined:
- A redirect target with bits[1:0]≠0 sets `misaligned_o` (sticky until reset).
- The PC goes to `TRAP_VECTOR` instead of the target, through the TRAP state. TRAP lasts 1 cycle with `fetch_valid_o`=0, then goes to RUN, or to HOLD if stalled.
- The check is applied to pending targets at the moment they are applied.

When undefined:
- Bits[1:0] of every target are forced to 0.
- `misaligned_o` is tied 0.
- TRAP does not exist.

## Structure
- Package `pc_seq_pkg`:
  - `pc_seq_state_t` enum (BOOT, RUN, HOLD, TRAP).
  - `ADDR_W`=64.
  - `INSTR_BYTES`=4.
  - `CNT_W`=32.
- Sub-module `pc_next_sel`: combinational priority selector that produces `next_pc_o` from the state, pending register, and inputs.
- The FSM, pending register, and counter stay in `pc_sequencer`.

## Test plan
- Reset then `stall_i`=0, `fetch_ready_i`=1 → `pc_o` 0, 0, 4, 8, 12; `fetch_count_o` reaches 3 after the 3rd acceptance.
- `fetch_ready_i`=0 for 3 cycles in RUN → `pc_o` held at 8 and `fetch_valid_o`=1 throughout; advances to 12 one edge after ready returns.
- Stall held, `branch_taken_i` pulsed with target 0x40 then 0x80, stall released → `pc_o`=0x80 on the release edge and 0x40 is never fetched.
- PC forced to 64'hFFFF_FFFF_FFFF_FFFC, one accepted fetch → `pc_o`=0 with no flag.
- With `PC_SEQ_MISALIGN_TRAP_EN`, branch to 0x42 → `pc_o`=0x100, `misaligned_o`=1; without the macro → `pc_o`=0x40, `misaligned_o`=0.
- `rst_in` asserted mid-stream with a pending redirect → next edge `pc_o`=`RESET_VECTOR`, pending dropped, count 0.
